card_bus_arbiter: RTL
=====================

// Module: card_bus_arbiter
// PURPOSE
//   Sequences and arbitrates read-data responses from the slot cards (SuperSerial, SuperSprite,
//   Mockingboard) onto the shared Apple II bus data-out path.
//   Once per 6502 cycle it waits for address decode to settle, then grants one requester by
//   fixed priority. It holds the granted byte stable through phi0 plus a hold window, and flags
//   contention. It also merges card IRQs into the single bus IRQ line.
//   Sits between the card instances and apple_bus: data_out_en/data_out/irq_n.
// PARAMETERS
//   NUM_REQ         3   number of requesters; index 0 = highest priority
//   SAMPLE_DELAY    4   clk_logic cycles from phi0 start to request sample (>=1)
//   HOLD_CYCLES     2   clk_logic cycles data stays driven after phi0 ends (>=0)
//   IRQ_OUT_ENABLE  0   0: irq_n_o tied 1; 1: irq_n_o = registered AND of irq_n_i
//   CNT_W           16  width of conflict counter
// PORTS
//   clk_logic         in   1          logic clock (54 MHz)
//   system_reset_n    in   1          asynchronous, active-low reset
//   phi1_posedge_i    in   1          1-cycle pulse: phi0 ends
//   phi1_negedge_i    in   1          1-cycle pulse: phi0 begins (bus cycle start)
//   req_i             in   NUM_REQ    per-card read claim (rd_en), level
//   data_i            in   NUM_REQ*8  per-card read data; byte k = data_i[8k+7:8k]
//   irq_n_i           in   NUM_REQ    per-card active-low interrupt
//   data_out_en_o     out  1          drive bus data
//   data_out_o        out  8          byte to drive
//   grant_o           out  NUM_REQ    one-hot current grant (0 when not driving)
//   irq_n_o           out  1          merged active-low IRQ to bus
//   conflict_o        out  1          1-cycle pulse: >1 request at sample
//   conflict_count_o  out  CNT_W      saturating count of conflict pulses
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, outputs 0, irq_n_o=1, count=0.
//   FSM (T = cycle in which phi1_negedge_i is seen):
//     IDLE:   on phi1_negedge_i -> WAIT, load cnt=SAMPLE_DELAY-1.
//     WAIT:   decrement cnt; at cnt==0, sample req_i (cycle T+SAMPLE_DELAY):
//             req_i==0 -> IDLE; else grant lowest set index -> DRIVE.
//     DRIVE:  grant_o/data_out_en_o high from T+SAMPLE_DELAY+1.
//             data_out_o <= data_i[granted] each cycle (1-cycle latency, follows updates).
//             Granted req_i drops -> en/grant low next cycle, -> IDLE.
//             phi1_posedge_i -> HOLD with cnt=HOLD_CYCLES (HOLD_CYCLES=0 -> IDLE directly).
//     HOLD:   keep driving; data_out_o frozen at last DRIVE value; ignore req_i;
//             decrement, release (en/grant low) the cycle after cnt reaches 0 -> IDLE.
//   phi1_negedge_i in any non-IDLE state: abort current grant (en low next cycle), restart WAIT.
//   Grant fixed for the whole bus cycle; no re-arbitration if new requesters appear later.
//   conflict_o: pulse in cycle T+SAMPLE_DELAY+1 when popcount(req_i)>1 at sample.
//   conflict_count_o increments on the pulse and saturates at all-ones.
//   data_out_o = 0 whenever data_out_en_o = 0.
//   IRQ: irq_n_o registered 1 cycle after &irq_n_i (when IRQ_OUT_ENABLE=1).
//   It is not gated by the FSM.
// TESTING (SAMPLE_DELAY=4, HOLD_CYCLES=2, NUM_REQ=3)
//   req_i=010 from T+1, data byte1=A5 -> en=1, grant=010 at T+5; data_out=A5 at T+5;
//     phi1_posedge at P -> en=1 through P+2, en=0 at P+3.
//   req_i=101, bytes 11/33 -> grant=001, data_out=11, conflict_o pulse at T+5,
//     conflict_count_o = 1.
//   req_i=100 then dropped at T+7 -> en=0 at T+8, FSM IDLE, no conflict.
//   req_i=000 at sample -> en never asserts.
//     Preset count to FFFF with CNT_W=16 plus a conflict -> count stays FFFF.
//   system_reset_n low mid-DRIVE -> en/grant/data=0 same cycle, irq_n_o=1.
//     After release, the next bus cycle is arbitrated normally.
//   IRQ_OUT_ENABLE=1, irq_n_i=101 -> irq_n_o=0 one cycle later.
//     With IRQ_OUT_ENABLE=0 it stays 1.

Source files
------------

// File: rtl/card_bus_arbiter.sv
// Per-6502-cycle read-data arbiter for the slot cards: samples card claims after decode
// settles, drives the winning byte through phi0 plus a hold window, and merges card IRQs.
module card_bus_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int SAMPLE_DELAY   = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int IRQ_OUT_ENABLE = 0,
    parameter int CNT_W          = 16
) (
    input  logic                 clk_logic,
    input  logic                 system_reset_n,
    input  logic                 phi1_posedge_i,
    input  logic                 phi1_negedge_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] data_i,
    input  logic [NUM_REQ-1:0]   irq_n_i,
    output logic                 data_out_en_o,
    output logic [7:0]           data_out_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 irq_n_o,
    output logic                 conflict_o,
    output logic [CNT_W-1:0]     conflict_count_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE, ST_HOLD} state_t;

    // Counters hold "cycles remaining minus one" so the terminal test is always cnt == 0.
    localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLE_DELAY - 1);
    localparam logic [7:0] HOLD_LOAD   = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 conflict_q, conflict_d;
    logic [CNT_W-1:0]     count_q;
    logic                 irq_q;
    logic [7:0]           data_q;

    logic [NUM_REQ-1:0]   pri_grant;
    logic [NUM_REQ-1:0]   sel_grant;
    logic [7:0]           data_sel;
    logic                 multi_req;
    logic                 sample;
    logic                 held_req;
    logic                 load_data;

    always_comb begin
        pri_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                pri_grant    = '0;
                pri_grant[k] = 1'b1;
            end
        end
        multi_req = |(req_i & (req_i - NUM_REQ'(1)));
        sample    = (state_q == ST_WAIT) && (cnt_q == 8'd0);
        held_req  = |(req_i & grant_q);
        sel_grant = sample ? pri_grant : grant_q;
        load_data = sample || (state_q == ST_DRIVE);
        data_sel  = 8'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_grant[k]) data_sel = data_i[8*k +: 8];
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            grant_q    <= '0;
            conflict_q <= 1'b0;
            count_q    <= '0;
            irq_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            conflict_q <= conflict_d;
            irq_q      <= &irq_n_i;
            if (conflict_q && (count_q != '1)) count_q <= count_q + CNT_W'(1);
        end
    end

    // Byte register is frozen outside sample/DRIVE; the output gate hides it while idle.
    always_ff @(posedge clk_logic) begin
        if (load_data) data_q <= data_sel;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        conflict_d = 1'b0;
        if (phi1_negedge_i) begin
            state_d = ST_WAIT;
            cnt_d   = SAMPLE_LOAD;
            grant_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: grant_d = '0;
                ST_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        conflict_d = multi_req;
                        if (req_i == '0) begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end else begin
                            state_d = ST_DRIVE;
                            grant_d = pri_grant;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!held_req) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else if (phi1_posedge_i) begin
                        if (HOLD_CYCLES == 0) begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        data_out_en_o    = |grant_q;
        grant_o          = grant_q;
        data_out_o       = data_out_en_o ? data_q : 8'd0;
        conflict_o       = conflict_q;
        conflict_count_o = count_q;
        irq_n_o          = (IRQ_OUT_ENABLE != 0) ? irq_q : 1'b1;
    end

endmodule
